// File: rtl/in1_debounce_pkg.sv
// Shared definitions for the In1 input-conditioning stage: FSM state encoding
// and default synchroniser / debounce lengths.
package in1_debounce_pkg;

  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int DEFAULT_DB_CYCLES   = 16;

  typedef enum logic [1:0] {
    S_LOW      = 2'b00,
    S_CHK_HIGH = 2'b01,
    S_HIGH     = 2'b10,
    S_CHK_LOW  = 2'b11
  } state_e;

endpackage

// File: rtl/in1_sync.sv
// Plain flop-chain synchroniser bringing an asynchronous level into the clk domain.
// No logic is placed between stages so each flop has a full cycle to resolve.
module in1_sync
  import in1_debounce_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign dout = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/in1_debounce.sv
// Synchronise + debounce a raw level for the sequence-detector In1 input.
// Define IN1_DEBOUNCE_GLITCH_CNT_EN to add the saturating Glitch_Cnt output.
module in1_debounce
  import in1_debounce_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int DB_CYCLES   = DEFAULT_DB_CYCLES,
  parameter int CNT_W       = 5
`ifdef IN1_DEBOUNCE_GLITCH_CNT_EN
  ,
  parameter int GLITCH_W    = 8
`endif
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                Raw_In,
  output logic                Out1,
  output logic                Rise,
  output logic                Fall
`ifdef IN1_DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [GLITCH_W-1:0] Glitch_Cnt
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  in1_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (CLK),
    .rst  (RST),
    .din  (Raw_In),
    .dout (s)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_LOW;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // The entering sample already counts as 1, so acceptance happens on cnt == DB_CYCLES-1.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      S_LOW: begin
        if (s) begin
          state_d = S_CHK_HIGH;
          cnt_d   = CNT_W'(1);
        end
      end
      S_CHK_HIGH: begin
        if (!s) begin
          state_d = S_LOW;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HIGH;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HIGH: begin
        if (!s) begin
          state_d = S_CHK_LOW;
          cnt_d   = CNT_W'(1);
        end
      end
      S_CHK_LOW: begin
        if (s) begin
          state_d = S_HIGH;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_LOW;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_LOW;
      end
    endcase
  end

  always_comb begin
    Out1 = (state_q == S_HIGH) || (state_q == S_CHK_LOW);
    Rise = rise_q;
    Fall = fall_q;
  end

`ifdef IN1_DEBOUNCE_GLITCH_CNT_EN
  logic [GLITCH_W-1:0] glitch_q, glitch_d;
  logic                abort;

  // An abort is any CHK state falling back to the level it came from.
  always_comb begin
    abort    = ((state_q == S_CHK_HIGH) && !s) || ((state_q == S_CHK_LOW) && s);
    glitch_d = glitch_q;
    if (abort && (glitch_q != '1)) begin
      glitch_d = glitch_q + GLITCH_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      glitch_q <= '0;
    end else begin
      glitch_q <= glitch_d;
    end
  end

  assign Glitch_Cnt = glitch_q;
`endif

endmodule

// File: tb/tb_in1_debounce.sv
// Self-checking bench for in1_debounce: directed latency/glitch/reset scenarios
// plus randomized level runs, checked against a run-length reference model.
module tb_in1_debounce;
  import in1_debounce_pkg::*;

  localparam int SYNC = DEFAULT_SYNC_STAGES;
  localparam int DB   = DEFAULT_DB_CYCLES;
  localparam int LAT  = SYNC + DB;

  logic CLK = 1'b0;
  logic RST;
  logic Raw_In;
  logic Out1;
  logic Rise;
  logic Fall;
`ifdef IN1_DEBOUNCE_GLITCH_CNT_EN
  localparam int GW      = 8;
  localparam int GLITCH_MAX = (1 << GW) - 1;
  logic [GW-1:0] Glitch_Cnt;
`endif

  always #5 CLK = ~CLK;

  in1_debounce dut (
    .CLK    (CLK),
    .RST    (RST),
    .Raw_In (Raw_In),
    .Out1   (Out1),
    .Rise   (Rise),
    .Fall   (Fall)
`ifdef IN1_DEBOUNCE_GLITCH_CNT_EN
    ,
    .Glitch_Cnt (Glitch_Cnt)
`endif
  );

  int compareCount  = 0;
  int mismatchCount = 0;

  // Reference model: remembers every raw sample by edge number and accepts a
  // new level once DB consecutive delayed samples disagree with the current one.
  int   edgeNum     = 0;
  int   lastRstEdge = -1000;
  logic rawAt[$];
  logic modelOut    = 1'b0;
  int   modelRun    = 0;
  logic modelRise   = 1'b0;
  logic modelFall   = 1'b0;
  int   modelGlitch = 0;

  int   riseSeen = 0;
  int   fallSeen = 0;
  int   toggles  = 0;
  logic prevOut  = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h (edge %0d)",
               tag, observed, expected, edgeNum);
    end
  endtask

  task automatic modelStep(input logic raw, input logic rst);
    logic s;
    rawAt.push_back(raw);
    modelRise = 1'b0;
    modelFall = 1'b0;
    if (rst) begin
      lastRstEdge = edgeNum;
      modelOut    = 1'b0;
      modelRun    = 0;
      modelGlitch = 0;
    end else begin
      s = ((edgeNum - SYNC) > lastRstEdge && (edgeNum - SYNC) >= 0)
          ? rawAt[edgeNum - SYNC] : 1'b0;
      if (s != modelOut) begin
        modelRun++;
        if (modelRun == DB) begin
          modelOut  = s;
          modelRise = s;
          modelFall = !s;
          modelRun  = 0;
        end
      end else begin
        if (modelRun > 0 && modelGlitch < 255) modelGlitch++;
        modelRun = 0;
      end
    end
    edgeNum++;
  endtask

  task automatic applyStimulus(input logic raw, input logic rst);
    @(negedge CLK);
    Raw_In = raw;
    RST    = rst;
    @(posedge CLK);
    modelStep(raw, rst);
    #1;
    checkOutput("out_rise_fall", 32'({Out1, Rise, Fall}),
                32'({modelOut, modelRise, modelFall}));
`ifdef IN1_DEBOUNCE_GLITCH_CNT_EN
    checkOutput("glitch_cnt", 32'(Glitch_Cnt), 32'(modelGlitch));
`endif
    if (Rise === 1'b1) riseSeen++;
    if (Fall === 1'b1) fallSeen++;
    if (Out1 !== prevOut) toggles++;
    prevOut = Out1;
  endtask

  task automatic waitLevel(input logic raw, input logic level, output int n);
    n = 0;
    do begin
      applyStimulus(raw, 1'b0);
      n++;
    end while (Out1 !== level && n < 100);
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    RST    = 1'b1;
    Raw_In = 1'b0;
    repeat (3) applyStimulus(1'b0, 1'b1);
    checkOutput("reset_state", 32'({Out1, Rise, Fall}), 32'd0);

    repeat (40) applyStimulus(1'b0, 1'b0);
    checkOutput("idle_low", 32'(Out1), 32'd0);

    waitLevel(1'b1, 1'b1, n);
    checkOutput("rise_latency", 32'(n), 32'(LAT));
    checkOutput("rise_pulse", 32'(Rise), 32'd1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("rise_one_cycle", 32'(Rise), 32'd0);
    repeat (30) applyStimulus(1'b1, 1'b0);

    waitLevel(1'b0, 1'b0, n);
    checkOutput("fall_latency", 32'(n), 32'(LAT));
    checkOutput("fall_pulse", 32'(Fall), 32'd1);
    repeat (30) applyStimulus(1'b0, 1'b0);

    // A bounce shorter than the debounce window must be swallowed entirely.
    riseSeen = 0;
    repeat (10) applyStimulus(1'b1, 1'b0);
    repeat (30) applyStimulus(1'b0, 1'b0);
    checkOutput("short_bounce_no_rise", 32'(riseSeen), 32'd0);
    checkOutput("short_bounce_out", 32'(Out1), 32'd0);
`ifdef IN1_DEBOUNCE_GLITCH_CNT_EN
    checkOutput("short_bounce_glitch", 32'(Glitch_Cnt), 32'd1);
`endif

    for (int i = 0; i < 300; i++) begin
      repeat (5) applyStimulus(1'b1, 1'b0);
      repeat (5) applyStimulus(1'b0, 1'b0);
    end
    repeat (10) applyStimulus(1'b0, 1'b0);
    checkOutput("bounce_train_out", 32'(Out1), 32'd0);
    checkOutput("bounce_train_no_rise", 32'(riseSeen), 32'd0);
`ifdef IN1_DEBOUNCE_GLITCH_CNT_EN
    checkOutput("glitch_saturated", 32'(Glitch_Cnt), 32'(GLITCH_MAX));
`endif

    // Reset on the 10th edge of qualification restarts the full latency.
    repeat (30) applyStimulus(1'b0, 1'b0);
    repeat (9) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("rst_mid_out", 32'(Out1), 32'd0);
    waitLevel(1'b1, 1'b1, n);
    checkOutput("rst_requalify_latency", 32'(n), 32'(LAT));

    waitLevel(1'b0, 1'b0, n);
    checkOutput("fall_latency_2", 32'(n), 32'(LAT));
    repeat (30) applyStimulus(1'b0, 1'b0);

    // Downstream-style 1,1,0 pattern of 30-cycle levels.
    riseSeen = 0;
    fallSeen = 0;
    toggles  = 0;
    prevOut  = Out1;
    repeat (60) applyStimulus(1'b1, 1'b0);
    repeat (60) applyStimulus(1'b0, 1'b0);
    checkOutput("pattern_rises", 32'(riseSeen), 32'd1);
    checkOutput("pattern_falls", 32'(fallSeen), 32'd1);
    checkOutput("pattern_toggles", 32'(toggles), 32'd2);

    for (int seg = 0; seg < 80; seg++) begin
      logic lvl;
      int   len;
      lvl = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 40));
      for (int k = 0; k < len; k++) begin
        applyStimulus(lvl, ($urandom_range(0, 199) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
